// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM stage: drives a split
// req/addr_ok/data_ok bus, holds the pipeline while busy, bounds each access.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        mem_valid,
    input  logic        mem_is_load,
    input  logic [3:0]  mem_ram_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        ext_stall,
    output logic        suspend,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              wr_q;
    logic              is_load_q;
    logic              acc;
    logic              is_store;

    assign is_store = |mem_ram_we;
    assign acc      = mem_valid & (mem_is_load | is_store);

    assign suspend = ext_stall
                   | ((state == S_IDLE) & acc)
                   | (state == S_REQ)
                   | (state == S_WAIT);

    // Bus fields come only from the latched copy and read as zero outside a request.
    assign data_wr    = data_req & wr_q;
    assign data_wstrb = {4{data_req}} & wstrb_q;
    assign data_addr  = {32{data_req}} & addr_q;
    assign data_wdata = {32{data_req}} & wdata_q;

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wr_q        <= 1'b0;
            is_load_q   <= 1'b0;
            data_req    <= 1'b0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (acc) begin
                        // A store wins over a load flag set on the same entry.
                        addr_q    <= mem_addr;
                        wdata_q   <= is_store ? mem_wdata : '0;
                        wstrb_q   <= mem_ram_we;
                        wr_q      <= is_store;
                        is_load_q <= mem_is_load & ~is_store;
                        cnt       <= '0;
                        data_req  <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (data_addr_ok && data_data_ok) begin
                        if (is_load_q) begin
                            rdata_out <= data_rdata;
                        end
                        data_req    <= 1'b0;
                        rdata_valid <= 1'b1;
                        state       <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata_out   <= '0;
                        bus_err     <= 1'b1;
                        data_req    <= 1'b0;
                        rdata_valid <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        if (data_addr_ok) begin
                            data_req <= 1'b0;
                            state    <= S_WAIT;
                        end
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (is_load_q) begin
                            rdata_out <= data_rdata;
                        end
                        rdata_valid <= 1'b1;
                        state       <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata_out   <= '0;
                        bus_err     <= 1'b1;
                        rdata_valid <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (!ext_stall) begin
                        rdata_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    data_req    <= 1'b0;
                    rdata_valid <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed accesses push expected bus
// requests and responses; a negedge monitor pops and compares them.
module tb_mem_access_ctrl;

    typedef struct packed {
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_exp_t;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic        mem_valid;
    logic        mem_is_load;
    logic [3:0]  mem_ram_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        ext_stall;
    logic        suspend;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] rdata_out;
    logic        rdata_valid;
    logic        bus_err;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Cycle counters sampled by the monitor, read as deltas by the stimulus.
    int susp_n  = 0;
    int req_n   = 0;
    int valid_n = 0;
    int err_n   = 0;

    // Bus responder settings.
    logic        bus_auto;
    int          ao_dly;
    int          do_dly;
    logic [31:0] rd_base;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(16)
    ) dut (
        .cpu_clk(cpu_clk),
        .cpu_rstn(cpu_rstn),
        .mem_valid(mem_valid),
        .mem_is_load(mem_is_load),
        .mem_ram_we(mem_ram_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .ext_stall(ext_stall),
        .suspend(suspend),
        .data_req(data_req),
        .data_wr(data_wr),
        .data_wstrb(data_wstrb),
        .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .rdata_out(rdata_out),
        .rdata_valid(rdata_valid),
        .bus_err(bus_err)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_bus(input int a, input int d, input logic [31:0] rd);
        ao_dly  = a;
        do_dly  = d;
        rd_base = rd;
    endtask

    task automatic start_access(input logic ld, input logic [3:0] we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] exp_rd,
                                input logic exp_err, input logic exp_resp);
        bus_exp_t  b;
        resp_exp_t r;
        mem_valid   = 1'b1;
        mem_is_load = ld;
        mem_ram_we  = we;
        mem_addr    = a;
        mem_wdata   = wd;
        b.wr    = |we;
        b.strb  = we;
        b.addr  = a;
        b.wdata = (|we) ? wd : 32'h0;
        bus_q.push_back(b);
        if (exp_resp) begin
            r.rdata = exp_rd;
            r.err   = exp_err;
            resp_q.push_back(r);
        end
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40 && !rdata_valid; i++) tick();
        chk({nm, "_done_seen"}, {31'b0, rdata_valid}, 32'h1);
    endtask

    // Bus model: addr_ok ao_dly cycles into REQ, data_ok do_dly cycles after that.
    initial begin
        int          k;
        logic        active;
        logic [31:0] req_addr;
        k            = 0;
        active       = 1'b0;
        req_addr     = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        forever begin
            @(posedge cpu_clk);
            #2;
            if (!bus_auto) begin
                active = 1'b0;
                continue;
            end
            if (active && (rdata_valid || k >= ao_dly + do_dly)) active = 1'b0;
            if (!active && data_req) begin
                active   = 1'b1;
                k        = 0;
                req_addr = data_addr;
            end else if (active) begin
                k++;
            end
            data_addr_ok = active && data_req && (k == ao_dly);
            data_data_ok = active && (k == ao_dly + do_dly);
            data_rdata   = data_data_ok ? (rd_base ^ req_addr) : 32'h0;
        end
    end

    // Monitor / scoreboard.
    logic prev_req   = 1'b0;
    logic prev_valid = 1'b0;

    always @(negedge cpu_clk) begin
        if (suspend)     susp_n++;
        if (data_req)    req_n++;
        if (rdata_valid) valid_n++;
        if (bus_err)     err_n++;

        if (data_req) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected_req", 32'h1, 32'h0);
            end else begin
                chk("bus_addr", data_addr, bus_q[0].addr);
                chk("bus_wdata", data_wdata, bus_q[0].wdata);
                chk("bus_wr_strb", {27'b0, data_wr, data_wstrb}, {27'b0, bus_q[0].wr, bus_q[0].strb});
            end
        end else begin
            chk("bus_idle_zero", data_addr | data_wdata | {27'b0, data_wr, data_wstrb}, 32'h0);
            if (prev_req && bus_q.size() > 0) void'(bus_q.pop_front());
        end

        if (rdata_valid) begin
            if (resp_q.size() == 0) begin
                chk("resp_unexpected_valid", 32'h1, 32'h0);
            end else begin
                chk("resp_rdata", rdata_out, resp_q[0].rdata);
                chk("resp_bus_err", {31'b0, bus_err}, {31'b0, resp_q[0].err & ~prev_valid});
            end
        end else begin
            chk("bus_err_outside_done", {31'b0, bus_err}, 32'h0);
            if (prev_valid && resp_q.size() > 0) void'(resp_q.pop_front());
        end

        prev_req   = data_req;
        prev_valid = rdata_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, v0, e0;
        cpu_rstn    = 1'b0;
        mem_valid   = 1'b0;
        mem_is_load = 1'b0;
        mem_ram_we  = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        ext_stall   = 1'b0;
        bus_auto    = 1'b1;
        set_bus(0, 0, 32'h0);
        tick();
        tick();

        // Reset values
        chk("rst_data_req", {31'b0, data_req}, 32'h0);
        chk("rst_rdata_valid", {31'b0, rdata_valid}, 32'h0);
        chk("rst_rdata_out", rdata_out, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
        chk("rst_suspend", {31'b0, suspend}, 32'h0);
        ext_stall = 1'b1;
        #1 chk("rst_suspend_stall", {31'b0, suspend}, 32'h1);
        ext_stall = 1'b0;
        tick();
        cpu_rstn = 1'b1;
        tick();

        // Zero-wait load
        set_bus(0, 0, 32'hDEAD_BEEF ^ 32'h1000_0004);
        s0 = susp_n; r0 = req_n; v0 = valid_n;
        start_access(1'b1, 4'b0000, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        #1 chk("t1_suspend_first", {31'b0, suspend}, 32'h1);
        wait_done("t1");
        tick();
        mem_valid = 1'b0;
        tick();
        tick();
        chk("t1_req_cycles", req_n - r0, 1);
        chk("t1_suspend_cycles", susp_n - s0, 2);
        chk("t1_valid_cycles", valid_n - v0, 1);

        // Waited store: addr_ok after 3 REQ cycles, data_ok 2 cycles later
        set_bus(3, 2, 32'h5555_AAAA);
        s0 = susp_n; r0 = req_n; v0 = valid_n;
        start_access(1'b0, 4'b0011, 32'h2000_0010, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 1'b1);
        wait_done("t2");
        tick();
        mem_valid  = 1'b0;
        mem_ram_we = '0;
        tick();
        tick();
        chk("t2_req_cycles", req_n - r0, 4);
        chk("t2_suspend_cycles", susp_n - s0, 7);
        chk("t2_valid_cycles", valid_n - v0, 1);

        // Timeout with a silent bus, then a late data_ok
        set_bus(1000, 0, 32'h0);
        s0 = susp_n; r0 = req_n; v0 = valid_n; e0 = err_n;
        start_access(1'b1, 4'b0000, 32'h3000_0000, 32'h0, 32'h0, 1'b1, 1'b1);
        wait_done("t3");
        tick();
        mem_valid = 1'b0;
        bus_auto  = 1'b0;
        tick();
        data_data_ok = 1'b1;
        data_rdata   = 32'hFFFF_FFFF;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        chk("t3_late_no_valid", {31'b0, rdata_valid}, 32'h0);
        chk("t3_late_no_req", {31'b0, data_req}, 32'h0);
        chk("t3_late_rdata_kept", rdata_out, 32'h0);
        chk("t3_late_no_suspend", {31'b0, suspend}, 32'h0);
        bus_auto = 1'b1;
        tick();
        chk("t3_req_cycles", req_n - r0, 8);
        chk("t3_suspend_cycles", susp_n - s0, 9);
        chk("t3_valid_cycles", valid_n - v0, 1);
        chk("t3_err_pulses", err_n - e0, 1);

        // ext_stall held across DONE for 3 cycles
        set_bus(0, 0, 32'h0BAD_F00D ^ 32'h1000_0008);
        v0 = valid_n; e0 = err_n;
        start_access(1'b1, 4'b0000, 32'h1000_0008, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
        wait_done("t4");
        ext_stall = 1'b1;
        #1 chk("t4_suspend_d0", {31'b0, suspend}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t4_stall_valid", {31'b0, rdata_valid}, 32'h1);
            chk("t4_stall_suspend", {31'b0, suspend}, 32'h1);
        end
        tick();
        ext_stall = 1'b0;
        chk("t4_still_done", {31'b0, rdata_valid}, 32'h1);
        tick();
        mem_valid = 1'b0;
        chk("t4_back_idle", {31'b0, rdata_valid}, 32'h0);
        tick();
        chk("t4_valid_cycles", valid_n - v0, 4);
        chk("t4_no_err", err_n - e0, 0);

        // Reset while in WAIT; the stale data_ok arrives later
        set_bus(0, 4, 32'h7777_7777 ^ 32'h4000_0000);
        v0 = valid_n;
        start_access(1'b1, 4'b0000, 32'h4000_0000, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("t5_in_req", {31'b0, data_req}, 32'h1);
        tick();
        chk("t5_in_wait_req", {31'b0, data_req}, 32'h0);
        chk("t5_in_wait_suspend", {31'b0, suspend}, 32'h1);
        cpu_rstn  = 1'b0;
        mem_valid = 1'b0;
        tick();
        cpu_rstn = 1'b1;
        chk("t5_rst_req", {31'b0, data_req}, 32'h0);
        chk("t5_rst_valid", {31'b0, rdata_valid}, 32'h0);
        chk("t5_rst_suspend", {31'b0, suspend}, 32'h0);
        repeat (5) tick();
        chk("t5_no_valid_after", valid_n - v0, 0);

        // Back-to-back loads with mem_valid held high
        set_bus(0, 0, 32'hA5A5_0000);
        start_access(1'b1, 4'b0000, 32'h5000_0000, 32'h0, 32'hF5A5_0000, 1'b0, 1'b1);
        wait_done("t6a");
        tick();
        start_access(1'b1, 4'b0000, 32'h5000_0040, 32'h0, 32'hF5A5_0040, 1'b0, 1'b1);
        #1 chk("t6_bubble_suspend", {31'b0, suspend}, 32'h1);
        tick();
        chk("t6_second_req", {31'b0, data_req}, 32'h1);
        tick();
        chk("t6_second_done", {31'b0, rdata_valid}, 32'h1);
        tick();
        mem_valid = 1'b0;
        tick();
        tick();

        chk("end_bus_q_empty", bus_q.size(), 0);
        chk("end_resp_q_empty", resp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
